// File: rtl/fpu_op_sequencer.sv
// rtl/fpu_op_sequencer.sv - sequences A/B operand collection and the FPU strobe/ack handshakes
module fpu_op_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned CNT_W          = 16,
  parameter logic [31:0] TIMEOUT_NAN    = 32'h7FC0_0000
) (
  input  logic             clk,
  input  logic             rsto,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op_in,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_op,
  output logic             fpu_a_stb,
  input  logic             fpu_a_ack,
  output logic             fpu_b_stb,
  input  logic             fpu_b_ack,
  input  logic [31:0]      fpu_z,
  input  logic             fpu_z_stb,
  output logic             fpu_z_ack,
  output logic             fpu_rst_req,
  output logic [31:0]      res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int unsigned   TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_GET_A, S_GET_B, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RESULT
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [31:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]        op_q, op_d;
  logic              to_q, to_d, rst_req_q, rst_req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              phase_active, at_limit, timeout;

  assign at_limit = (tmr_q == T_LAST);

  always_ff @(posedge clk or posedge rsto) begin
    if (rsto) state_q <= S_GET_A;
    else      state_q <= state_d;
  end

  // An ack seen in the threshold cycle takes priority over the timeout.
  always_comb begin
    state_d      = state_q;
    phase_active = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      S_GET_A:  if (in_valid) state_d = S_GET_B;
      S_GET_B:  if (in_valid) state_d = S_SEND_A;
      S_SEND_A: begin
        phase_active = 1'b1;
        if (fpu_a_ack)     state_d = S_SEND_B;
        else if (at_limit) begin state_d = S_RESULT; timeout = 1'b1; end
      end
      S_SEND_B: begin
        phase_active = 1'b1;
        if (fpu_b_ack)     state_d = S_WAIT_Z;
        else if (at_limit) begin state_d = S_RESULT; timeout = 1'b1; end
      end
      S_WAIT_Z: begin
        phase_active = 1'b1;
        if (fpu_z_stb)     state_d = S_RESULT;
        else if (at_limit) begin state_d = S_RESULT; timeout = 1'b1; end
      end
      S_RESULT: if (res_ready) state_d = S_GET_A;
      default:  state_d = S_GET_A;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    fpu_a_stb = 1'b0;
    fpu_b_stb = 1'b0;
    fpu_z_ack = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_GET_A:  begin in_ready = 1'b1; busy = 1'b0; end
      S_GET_B:  in_ready  = 1'b1;
      S_SEND_A: fpu_a_stb = 1'b1;
      S_SEND_B: fpu_b_stb = 1'b1;
      S_WAIT_Z: fpu_z_ack = 1'b1;
      S_RESULT: res_valid = 1'b1;
      default:  busy      = 1'b1;
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    to_d      = to_q;
    rst_req_d = 1'b0;
    cnt_d     = cnt_q;
    tmr_d     = '0;
    if (state_q == S_GET_A && in_valid) begin
      a_d  = in_data;
      op_d = op_in;
    end
    if (state_q == S_GET_B && in_valid) b_d = in_data;
    if (state_q == S_WAIT_Z && fpu_z_stb) begin
      res_d = fpu_z;
      to_d  = 1'b0;
    end
    if (timeout) begin
      res_d     = TIMEOUT_NAN;
      to_d      = 1'b1;
      rst_req_d = 1'b1;
    end
    if (state_q == S_RESULT && res_ready) cnt_d = cnt_q + CNT_W'(1);
    // Counter restarts on every phase entry, including phase-to-phase moves.
    if (phase_active && state_d == state_q) tmr_d = tmr_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rsto) begin
    if (rsto) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_q     <= '0;
      to_q      <= 1'b0;
      rst_req_q <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      res_q     <= res_d;
      to_q      <= to_d;
      rst_req_q <= rst_req_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
    end
  end

  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign fpu_op      = op_q;
  assign res_data    = res_q;
  assign res_timeout = to_q;
  assign fpu_rst_req = rst_req_q;
  assign op_count    = cnt_q;

endmodule
